// File: rtl/aes_stream_pkg.sv
// Shared types and default sizing for the AES streaming front-end.
package aes_stream_pkg;

   localparam int unsigned AES_LATENCY   = 21;
   localparam int unsigned DEF_DEPTH     = 32;
   localparam int unsigned DEF_TAG_W     = 8;
   localparam int unsigned DEF_NKEYS     = 4;
   localparam int unsigned DEF_KEY_IDX_W = $clog2(DEF_NKEYS);
   localparam int unsigned DEF_CNT_W     = $clog2(DEF_DEPTH) + 1;

   typedef logic [127:0] aes_block_t;

endpackage

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryption core: 21-cycle latency, one block per cycle, never stalls.
module aes_128 (
   input  logic         clk,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254, then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      int src;
      o = '0;
      for (int b = 0; b < 16; b++) begin
         src = 4 * (((b / 4) + (b % 4)) % 4) + (b % 4);
         o[127-8*b -: 8] = sbox(s[127-8*src -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input int r);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 1; i < r; i++) v = xtime(v);
      return v;
   endfunction

   function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   logic [127:0] s_q  [0:10];
   logic [127:0] k_q  [0:9];
   logic [127:0] sa_q [1:10];
   logic [127:0] ka_q [1:10];

   // Initial AddRoundKey, then two register stages per round.
   always_ff @(posedge clk) begin
      s_q[0] <= state ^ key;
      k_q[0] <= key;
      for (int r = 1; r <= 10; r++) begin
         sa_q[r] <= sub_shift(s_q[r-1]);
         ka_q[r] <= key_exp(k_q[r-1], rcon(r));
         s_q[r]  <= ((r == 10) ? sa_q[r] : mix_cols(sa_q[r])) ^ ka_q[r];
      end
      for (int r = 1; r <= 9; r++) k_q[r] <= ka_q[r];
   end

   assign out = s_q[10];

endmodule

// File: rtl/aes_stream_fifo.sv
// Output buffer with registered head; push and pop may coincide at any occupancy.
module aes_stream_fifo #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned W     = 136
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic                   out_valid,
   output logic [W-1:0]           out_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr, rptr_n;
   logic [AW:0]   count_n;
   logic          do_pop, bypass;

   assign do_pop  = pop & out_valid;
   assign rptr_n  = rptr + AW'(do_pop);
   assign count_n = count + (AW+1)'(push) - (AW+1)'(do_pop);
   // Pushed word becomes the head directly when nothing else remains.
   assign bypass  = push && (count == (AW+1)'(do_pop));

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         wptr      <= wptr + AW'(push);
         rptr      <= rptr_n;
         count     <= count_n;
         out_valid <= (count_n != '0);
         out_data  <= bypass ? push_data : mem[rptr_n];
      end
   end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Valid/ready streaming wrapper around aes_128 with key table, tag pipe and credit-based admission.
module aes_stream_ctrl import aes_stream_pkg::*; #(
   parameter int unsigned LATENCY = AES_LATENCY,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TAG_W   = DEF_TAG_W,
   parameter int unsigned NKEYS   = DEF_NKEYS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     key_wr,
   input  logic [$clog2(NKEYS)-1:0] key_idx,
   input  logic [127:0]             key_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [127:0]             in_data,
   input  logic [$clog2(NKEYS)-1:0] in_key_sel,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [127:0]             out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic [31:0]              done_cnt
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   aes_block_t                    keytab [NKEYS];
   logic [LATENCY-1:0]            pipe_vld;
   logic [LATENCY-1:0][TAG_W-1:0] pipe_tag;
   aes_block_t                    core_state, core_key, core_out;
   logic                          accept, exit_vld, pop;
   logic [CNT_W-1:0]              fifo_count, fifo_count_n, inflight_n;
   logic [128+TAG_W-1:0]          fifo_q;

   assign accept       = in_valid & in_ready;
   assign exit_vld     = pipe_vld[LATENCY-1];
   assign pop          = out_valid & out_ready;
   assign core_state   = accept ? in_data : '0;
   assign core_key     = accept ? keytab[in_key_sel] : '0;
   assign inflight_n   = inflight + CNT_W'(accept) - CNT_W'(exit_vld);
   assign fifo_count_n = fifo_count + CNT_W'(exit_vld) - CNT_W'(pop);

   // Writes land at the edge, so a same-cycle accept still reads the old key.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NKEYS); i++) keytab[i] <= '0;
      end else if (key_wr) begin
         keytab[key_idx] <= key_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_tag <= '0;
      end else begin
         pipe_vld <= {pipe_vld[LATENCY-2:0], accept};
         pipe_tag <= {pipe_tag[LATENCY-2:0], (accept ? in_tag : TAG_W'(0))};
      end
   end

   // Credit check uses next-state counts so in_ready is a plain register.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         done_cnt <= '0;
         in_ready <= 1'b0;
      end else begin
         inflight <= inflight_n;
         done_cnt <= done_cnt + 32'(pop);
         in_ready <= ({1'b0, fifo_count_n} + {1'b0, inflight_n}) < (CNT_W+1)'(DEPTH);
      end
   end

   aes_128 u_core (
      .clk   (clk),
      .state (core_state),
      .key   (core_key),
      .out   (core_out)
   );

   aes_stream_fifo #(
      .DEPTH (DEPTH),
      .W     (128 + TAG_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (exit_vld),
      .push_data ({core_out, pipe_tag[LATENCY-1]}),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (fifo_q),
      .count     (fifo_count)
   );

   assign out_data = fifo_q[TAG_W +: 128];
   assign out_tag  = fifo_q[TAG_W-1:0];

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Randomized self-checking bench for aes_stream_ctrl against a block-level AES/queue model.
module tb_aes_stream_ctrl;
   import aes_stream_pkg::*;

   localparam int DEPTH = 32;
   localparam int LAT   = 21;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     key_wr;
   logic [DEF_KEY_IDX_W-1:0] key_idx;
   logic [127:0]             key_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [127:0]             in_data;
   logic [DEF_KEY_IDX_W-1:0] in_key_sel;
   logic [7:0]               in_tag;
   logic                     out_valid;
   logic                     out_ready;
   logic [127:0]             out_data;
   logic [7:0]               out_tag;
   logic [DEF_CNT_W-1:0]     inflight;
   logic [31:0]              done_cnt;

   aes_stream_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .key_wr     (key_wr),
      .key_idx    (key_idx),
      .key_data   (key_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key_sel (in_key_sel),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .inflight   (inflight),
      .done_cnt   (done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic [7:0]   tag;
   } exp_t;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   sb [256];
   logic [127:0] m_key [4];
   exp_t         exp_q [$];
   int           pend [$];
   int           m_buf;
   logic [31:0]  m_done;
   int           cyc;
   int           dut_acc;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box by exhaustive inverse search plus bitwise affine map.
   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
         sb[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gf_mul(t[4*c], 2) ^ gf_mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 2) ^ gf_mul(t[4*c+2], 3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 2) ^ gf_mul(t[4*c+3], 3);
               s[4*c+3] = gf_mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 2);
            end
            for (int i = 0; i < 16; i++) t[i] = s[i];
         end
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_outputs();
      check("in_ready", 128'(in_ready), 128'((pend.size() + m_buf) < DEPTH));
      check("out_valid", 128'(out_valid), 128'(m_buf > 0));
      check("inflight", 128'(inflight), 128'(pend.size()));
      check("done_cnt", 128'(done_cnt), 128'(m_done));
      if (m_buf > 0) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_tag", 128'(out_tag), 128'(exp_q[0].tag));
      end
   endtask

   // Called at negedge with inputs already set; advances one clock.
   task automatic cycle_step();
      bit acc, pp;
      acc = in_valid && ((pend.size() + m_buf) < DEPTH);
      pp  = out_ready && (m_buf > 0);
      if (in_valid && in_ready) dut_acc++;
      if (acc) begin
         exp_q.push_back('{data: aes_enc(m_key[in_key_sel], in_data), tag: in_tag});
         pend.push_back(cyc + 1);
      end
      if (pp) begin
         void'(exp_q.pop_front());
         m_buf--;
         m_done++;
      end
      if (key_wr) m_key[key_idx] = key_data;
      @(posedge clk);
      cyc++;
      while (pend.size() > 0 && pend[0] + LAT <= cyc) begin
         void'(pend.pop_front());
         m_buf++;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      key_wr   = 0;
      key_idx  = 0;
      key_data = 0;
      in_valid = 0;
      in_data  = 0;
      in_key_sel = 0;
      in_tag   = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 0);
      check("rst_out_valid", 128'(out_valid), 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", 128'(out_tag), 0);
      check("rst_inflight", 128'(inflight), 0);
      check("rst_done_cnt", 128'(done_cnt), 0);
      pend.delete();
      exp_q.delete();
      m_buf  = 0;
      m_done = 0;
      for (int i = 0; i < 4; i++) m_key[i] = 0;
      cyc = 0;
      rst = 0;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain();
      int n;
      idle_inputs();
      out_ready = 1;
      n = 0;
      while ((pend.size() > 0 || m_buf > 0) && n < 200) begin
         cycle_step();
         n++;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         assert (!(dut.exit_vld && dut.fifo_count == DEF_CNT_W'(DEPTH) && !dut.pop))
         else begin
            errors++;
            $error("FAIL fifo_overflow count %0d", dut.fifo_count);
         end
      end
   end

   initial begin
      logic [127:0] k1, k2, pa, pb;
      logic [127:0] obs [2];
      logic [31:0]  base;
      int t0, n, nobs, thr;

      build_sbox();
      out_ready = 1;
      dut_acc = 0;
      cyc = 0;
      do_reset();

      // FIPS-197 known answer and first-output latency.
      key_wr = 1; key_idx = 0; key_data = 128'h000102030405060708090a0b0c0d0e0f;
      cycle_step();
      key_wr = 0; in_valid = 1; in_data = 128'h00112233445566778899aabbccddeeff;
      in_key_sel = 0; in_tag = 8'h5a;
      t0 = cyc;
      cycle_step();
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 40) begin
         cycle_step();
         n++;
      end
      check("fips_latency", 128'(cyc - t0), 22);
      check("fips_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check("fips_tag", 128'(out_tag), 128'h5a);
      drain();

      // 100 back-to-back blocks across four random keys.
      for (int s = 0; s < 4; s++) begin
         key_wr = 1; key_idx = DEF_KEY_IDX_W'(s); key_data = rand128();
         cycle_step();
      end
      key_wr = 0;
      base = m_done;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1; in_data = rand128();
         in_key_sel = DEF_KEY_IDX_W'($urandom_range(0, 3)); in_tag = 8'($urandom);
         cycle_step();
      end
      drain();
      check("stream_done", 128'(done_cnt), 128'(base + 100));

      // Backpressure: exactly DEPTH blocks admitted.
      out_ready = 0;
      dut_acc = 0;
      base = m_done;
      for (int i = 0; i < 60; i++) begin
         in_valid = 1; in_data = rand128();
         in_key_sel = DEF_KEY_IDX_W'($urandom_range(0, 3)); in_tag = 8'(i);
         cycle_step();
      end
      check("bp_accepted", 128'(dut_acc), 32);
      check("bp_credits", 128'(inflight) + 128'(dut.fifo_count), 32);
      drain();
      check("bp_drained", 128'(done_cnt), 128'(base + 32));

      // Key write racing an accept on the same slot.
      k1 = rand128(); k2 = rand128(); pa = rand128(); pb = rand128();
      key_wr = 1; key_idx = 1; key_data = k1;
      cycle_step();
      key_data = k2; in_valid = 1; in_key_sel = 1; in_data = pa; in_tag = 8'h11;
      cycle_step();
      key_wr = 0; in_data = pb; in_tag = 8'h22;
      cycle_step();
      idle_inputs();
      nobs = 0;
      n = 0;
      while (nobs < 2 && n < 60) begin
         if (out_valid && out_ready) begin
            obs[nobs] = out_data;
            nobs++;
         end
         cycle_step();
         n++;
      end
      check("race_count", 128'(nobs), 2);
      check("race_old_key", obs[0], aes_enc(k1, pa));
      check("race_new_key", obs[1], aes_enc(k2, pb));
      drain();

      // Reset with 10 blocks in flight and 5 buffered.
      out_ready = 0;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1; in_data = rand128(); in_key_sel = 2; in_tag = 8'(i);
         cycle_step();
      end
      in_valid = 0;
      n = 0;
      while (m_buf < 5 && n < 40) begin
         cycle_step();
         n++;
      end
      check("mid_inflight", 128'(inflight), 10);
      do_reset();
      out_ready = 1;
      for (int i = 0; i < 30; i++) cycle_step();
      in_valid = 1; in_data = 0; in_key_sel = 0; in_tag = 8'h77;
      cycle_step();
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 40) begin
         cycle_step();
         n++;
      end
      check("zero_key_data", out_data, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      check("zero_key_tag", 128'(out_tag), 128'h77);
      drain();

      // Random stall soak.
      thr = 50;
      for (int i = 0; i < 10000; i++) begin
         if (i % 1000 == 0) thr = int'($urandom_range(10, 90));
         in_valid   = ($urandom_range(0, 99) < 60);
         in_data    = rand128();
         in_key_sel = DEF_KEY_IDX_W'($urandom_range(0, 3));
         in_tag     = 8'($urandom);
         out_ready  = ($urandom_range(0, 99) < 32'(thr));
         key_wr     = ($urandom_range(0, 99) < 3);
         key_idx    = DEF_KEY_IDX_W'($urandom_range(0, 3));
         key_data   = rand128();
         cycle_step();
      end
      drain();
      check("soak_empty", 128'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Streaming front-end around the fully pipelined `aes_128` encryption core. It adds a valid/ready handshake, per-block tags, a multi-slot key table and an output buffer with backpressure. The core never stalls, so admission is credit-based: a block is accepted only when a buffer slot is guaranteed for it on exit. It sits between the host-side stream interface and the existing core, which is instantiated inside this block unchanged.

## Interface
Parameters:
- `LATENCY`, 21: core latency in cycles, from input sampling to `out` valid.
- `DEPTH`, 32: output buffer entries; must be ≥ `LATENCY`. Power of two.
- `TAG_W`, 8: width of the sideband tag carried with each block.
- `NKEYS`, 4: number of key slots. Power of two, ≥ 2.

Ports:
- `clk` in 1: single clock. Rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `key_wr` in 1: write strobe for the key table.
- `key_idx` in log2(NKEYS): key slot to write.
- `key_data` in 128: key value to write.
- `in_valid` in 1: input block valid.
- `in_ready` out 1: input block accepted when `in_valid & in_ready`.
- `in_data` in 128: plaintext block.
- `in_key_sel` in log2(NKEYS): key slot to use for this block.
- `in_tag` in TAG_W: sideband tag, returned unchanged with the result.
- `out_valid` out 1: output block valid.
- `out_ready` in 1: output block consumed when `out_valid & out_ready`.
- `out_data` out 128: ciphertext block.
- `out_tag` out TAG_W: tag of the output block.
- `inflight` out log2(DEPTH)+1: number of blocks currently inside the core.
- `done_cnt` out 32: count of blocks delivered on the output; wraps modulo 2^32.

## Operation
- Key table: `NKEYS`×128 registers, written on `key_wr`.
  - A block accepted in the same cycle as a write to its slot uses the old key.
  - The new key applies from the next cycle.
- Accept, when `in_valid & in_ready`:
  - Drive the core with `state=in_data` and `key=keytab[in_key_sel]`.
  - Push `{1, in_tag}` into a `LATENCY`-deep valid/tag shift register.
- Idle cycles: drive the core with zeros and push `{0, 0}` into the shift register.
- Shift-register exit with the valid bit set: push `{core out, tag}` into the output FIFO.
  - A FIFO overflow is impossible by construction; the bench checks this with an assertion.
- Credit rule: `in_ready = (fifo_count + inflight) < DEPTH`.
  - It depends only on registered counts, so there is no combinational path from `in_valid` or `out_ready`.
- `inflight`:
  - +1 on accept, −1 on pipe exit.
  - When both happen in the same cycle, it is unchanged.
- FIFO count: same rule, with push on pipe exit and pop on output handshake.
- Ordering is strict FIFO: output order equals acceptance order.
- `done_cnt` increments on each output handshake.
- Reset, including mid-operation:
  - Clears the valid/tag pipe, the FIFO pointers and counts, `inflight`, `done_cnt` and all key slots to 0.
  - In-flight and buffered blocks are discarded.
  - Output values during reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `inflight`=0, `done_cnt`=0.
  - The first cycle after reset deasserts: `in_ready`=1.

## Timing
- A block accepted at cycle t exits the core at t+LATENCY and is written to the FIFO on that edge.
- With an empty FIFO, `out_valid` asserts at cycle t+LATENCY+1. `out_data`/`out_tag` are registered FIFO outputs.
- Sustained throughput is 1 block/cycle while `out_ready`=1.
- Backpressure: once `out_ready`=0, at most `DEPTH` blocks can be outstanding, then `in_ready` drops.
- `in_ready` reasserts the cycle after the first output pop frees a credit.
- FIFO full and empty at the same time is impossible. Push and pop on the same cycle are supported at any occupancy.

## Structure
- Package `aes_stream_pkg`:
  - `AES_LATENCY = 21`
  - `typedef logic [127:0] aes_block_t`
  - the `clog2`-derived width constants
- Sub-module `aes_stream_fifo`: synchronous FIFO, `DEPTH`×(128+TAG_W), with registered outputs, `count` output, and push/pop allowed on the same cycle.
- Top level contains the key table, the valid/tag shift register, the credit counters and the `aes_128` instance.

## Test plan
- FIPS-197 vector: write slot 0 = 000102030405060708090a0b0c0d0e0f, send 00112233445566778899aabbccddeeff with tag 0x5A → `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_tag`=0x5A, `out_valid` first high at t+22.
- Streaming: 100 back-to-back blocks, random keys across 4 slots, `out_ready`=1 → `in_ready` stays 1, outputs in order, match the reference model, `done_cnt`=100.
- Backpressure: `out_ready`=0 with continuous `in_valid` → exactly 32 blocks accepted, then `in_ready`=0; `inflight`+FIFO count = 32. Release `out_ready` → all 32 drain in order.
- Key update race: write slot 1 in the same cycle a block using slot 1 is accepted → that block uses the old key; the next block uses the new key.
- Mid-stream reset: assert `rst` with 10 blocks in flight and 5 buffered → `out_valid` stays 0 afterwards, `inflight`=0, `done_cnt`=0, key slots read back as 0 (encrypt under slot 0: key 0, pt 0 → 66e94bd4ef8a2c3b884cfa59ca342b2e).
- Random stall soak: random `in_valid` and `out_ready` for 10k cycles → no loss, duplication or reordering; FIFO-overflow assertion never fires.
